// File: rtl/fp_issue_pkg.sv
// fp_issue_pkg: shared word type and credit helper for the FP issue controller.
package fp_issue_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp_word_t;

  // A request may issue only if every in-flight and buffered result still leaves one FIFO slot free.
  function automatic logic credit_avail(input int unsigned inflight,
                                        input int unsigned count,
                                        input int unsigned depth);
    return (inflight + count) < depth;
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: small show-ahead FIFO for completed FP results.
// The head entry is always visible on rd_data so the response port needs no extra read cycle.
module fp_result_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0],
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          wr_en,
  input  entry_t        wr_data,
  input  logic          rd_en,
  output entry_t        rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap explicitly so non-power-of-two depths would still index correctly.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage is not reset; only the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; a simultaneous write and read leaves count unchanged.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_next(wr_ptr);
      if (rd_en) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issues operand requests to a fixed-latency FP unit, tracks them with a
// valid/tag pipeline, buffers results in order and returns them over a valid/ready port.
// Optional feature macro: FP_ISSUE_BYPASS_EN -- present an arrival straight to the response
// port when the result FIFO is empty, skipping the FIFO if it is consumed that same cycle.
module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_word_t         req_a,
  input  fp_word_t         req_b,
  input  logic [TAG_W-1:0] req_tag,
  output fp_word_t         fpu_a,
  output fp_word_t         fpu_b,
  input  fp_word_t         fpu_q,
  output logic             resp_valid,
  input  logic             resp_ready,
  output fp_word_t         resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int IW = $clog2(LATENCY + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    fp_word_t         data;
    logic [TAG_W-1:0] tag;
  } fp_result_t;

  logic             stage_valid [LATENCY];
  logic [TAG_W-1:0] stage_tag   [LATENCY];
  logic [IW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fire;
  logic             arrival;
  logic             fifo_wr;
  logic             fifo_rd;
  fp_result_t       arrival_entry;
  fp_result_t       head_entry;
  fp_result_t       out_entry;

  // Operands go to the unit every cycle; only fired requests are tracked.
  assign fpu_a = req_a;
  assign fpu_b = req_b;

  // Credits come from registered counters only, so req_ready has no path from req_valid/resp_ready.
  assign req_ready = credit_avail(int'(inflight), int'(fifo_count), FIFO_DEPTH);
  assign fire      = req_valid && req_ready;
  assign arrival   = stage_valid[0];

  assign arrival_entry.data = fpu_q;
  assign arrival_entry.tag  = stage_tag[0];

  // Tracking pipeline: the top stage captures the fire, each lower stage takes the one above it.
  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic             nxt_valid;
      logic [TAG_W-1:0] nxt_tag;
      if (gi == LATENCY - 1) begin : g_top
        assign nxt_valid = fire;
        assign nxt_tag   = req_tag;
      end else begin : g_mid
        assign nxt_valid = stage_valid[gi+1];
        assign nxt_tag   = stage_tag[gi+1];
      end
      // One stage of the valid/tag shift register; reset discards anything in flight.
      always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
          stage_valid[gi] <= 1'b0;
          stage_tag[gi]   <= '0;
        end else begin
          stage_valid[gi] <= nxt_valid;
          stage_tag[gi]   <= nxt_tag;
        end
      end
    end
  endgenerate

  // In-flight count: +1 on fire, -1 on arrival, unchanged when both happen.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      inflight <= '0;
    end else if (fire && !arrival) begin
      inflight <= inflight + IW'(1);
    end else if (!fire && arrival) begin
      inflight <= inflight - IW'(1);
    end
  end

`ifdef FP_ISSUE_BYPASS_EN
  logic bypass;
  assign bypass     = fifo_empty && arrival;
  assign resp_valid = !fifo_empty || arrival;
  assign fifo_wr    = arrival && !(bypass && resp_ready);
  assign out_entry  = bypass ? arrival_entry : head_entry;
`else
  assign resp_valid = !fifo_empty;
  assign fifo_wr    = arrival;
  assign out_entry  = head_entry;
`endif

  assign fifo_rd   = !fifo_empty && resp_ready;
  // Zero the payload when idle so the port reads 0 out of reset.
  assign resp_data = resp_valid ? out_entry.data : '0;
  assign resp_tag  = resp_valid ? out_entry.tag  : '0;

  fp_result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fp_result_t)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .wr_en   (fifo_wr),
    .wr_data (arrival_entry),
    .rd_en   (fifo_rd),
    .rd_data (head_entry),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed table vectors and corner sequences on a LATENCY=1 instance,
// plus a randomized scoreboard run on a LATENCY=3 instance. Both attach a min-of-operands unit.
module tb_fp_issue_ctrl;

  localparam int TW   = 5;
  localparam int NOPS = 1000;
`ifdef FP_ISSUE_BYPASS_EN
  localparam int LR = 1;
`else
  localparam int LR = 2;
`endif

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic          v1, rdy1, rv1, rr1;
  logic [31:0]   a1, b1, fa1, fb1, q1, d1;
  logic [TW-1:0] t1, ot1;
  logic          v3, rdy3, rv3, rr3;
  logic [31:0]   a3, b3, fa3, fb3, q3, d3, s3a, s3b;
  logic [TW-1:0] t3, ot3;

  fp_issue_ctrl #(.LATENCY(1), .FIFO_DEPTH(4), .TAG_W(TW)) dut1 (
    .clk(clk), .areset(areset), .req_valid(v1), .req_ready(rdy1), .req_a(a1), .req_b(b1),
    .req_tag(t1), .fpu_a(fa1), .fpu_b(fb1), .fpu_q(q1), .resp_valid(rv1),
    .resp_ready(rr1), .resp_data(d1), .resp_tag(ot1));

  fp_issue_ctrl #(.LATENCY(3), .FIFO_DEPTH(4), .TAG_W(TW)) dut3 (
    .clk(clk), .areset(areset), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
    .req_tag(t3), .fpu_a(fa3), .fpu_b(fb3), .fpu_q(q3), .resp_valid(rv3),
    .resp_ready(rr3), .resp_data(d3), .resp_tag(ot3));

  function automatic logic [31:0] fmin(input logic [31:0] x, input logic [31:0] y);
    return (x < y) ? x : y;
  endfunction

  // Mock fixed-latency FP units (1 and 3 cycles), not reset: stale values survive DUT reset.
  always @(posedge clk) begin
    q1  <= fmin(fa1, fb1);
    s3a <= fmin(fa3, fb3);
    s3b <= s3a;
    q3  <= s3b;
  end

  typedef struct {
    logic          v;
    logic [31:0]   a, b;
    logic [TW-1:0] tag;
    logic          rr;
    logic          exp_ready, exp_rv;
    logic [31:0]   exp_data;
    logic [TW-1:0] exp_tag;
  } vec_t;

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sent, got, cyc;
  logic hold;
  logic [31:0]   hold_d;
  logic [TW-1:0] hold_t;
  sb_t  exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic addv(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] tg, input logic rr, input logic er,
                      input logic erv, input logic [31:0] ed, input logic [TW-1:0] et);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.tag = tg; t.rr = rr;
    t.exp_ready = er; t.exp_rv = erv; t.exp_data = ed; t.exp_tag = et;
    vecs.push_back(t);
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tg, input logic rr);
    v1 = v; a1 = a; b1 = b; t1 = tg; rr1 = rr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single op with 1.0 / 2.0 operands.
    for (int k = 0; k < 4; k++)
      addv(k == 0, 32'h3F800000, 32'h40000000, TW'(3), 1'b1, 1'b1, k == LR, 32'h3F800000, TW'(3));
    // Eight back-to-back requests, consumer always ready.
    for (int k = 0; k < 11; k++)
      addv(k < 8, 32'h40000000 + 32'(k), 32'h40800000, TW'(k), 1'b1, 1'b1,
           (k >= LR) && (k - LR < 8), 32'h40000000 + 32'(k - LR), TW'(k - LR));
    // Consumer stalled: four accepted, credits run out, then drain in order.
    for (int k = 0; k < 11; k++) begin
      int idx;
      idx = (k < 6) ? 0 : k - 6;
      addv(k < 6, 32'h41000000 + 32'(k), 32'h7F000000, TW'(k + 8), k >= 6,
           (k < 4) || (k >= 7), (k >= LR) && (k <= 9), 32'h41000000 + 32'(idx), TW'(8 + idx));
    end

    areset = 1'b0;
    drive1(1'b0, '0, '0, '0, 1'b0);
    v3 = 1'b0; a3 = '0; b3 = '0; t3 = '0; rr3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(rdy1), 32'd1);
    chk("reset_resp_valid", 32'(rv1), 32'd0);
    chk("reset_resp_data", d1, 32'd0);
    chk("reset_resp_tag", 32'(ot1), 32'd0);
    @(posedge clk); #1;
    areset = 1'b1;

    foreach (vecs[i]) begin
      drive1(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].rr);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(rdy1), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_resp_valid", i), 32'(rv1), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) begin
        chk($sformatf("vec%0d_resp_data", i), d1, vecs[i].exp_data);
        chk($sformatf("vec%0d_resp_tag", i), 32'(ot1), 32'(vecs[i].exp_tag));
      end
      $display("vec %0d: req_valid=%0b tag=%0d ready=%0b resp_valid=%0b resp_tag=%0d",
               i, v1, t1, rdy1, rv1, ot1);
      @(posedge clk); #1;
    end

    // Fire + arrival + drain in one cycle with count=2, inflight=1.
    for (int k = 0; k < 4; k++) begin
      drive1(1'b1, 32'h42000000 + 32'(10 + k), 32'h7F000000, TW'(10 + k), k == 3);
      @(negedge clk);
      chk($sformatf("simul_c%0d_ready", k), 32'(rdy1), 32'd1);
      if (k == 3) begin
        chk("simul_pre_inflight", 32'(dut1.inflight), 32'd1);
        chk("simul_pre_count", 32'(dut1.fifo_count), 32'd2);
        chk("simul_pre_tag", 32'(ot1), 32'd10);
      end
      @(posedge clk); #1;
    end
    drive1(1'b0, '0, '0, '0, 1'b1);
    chk("simul_post_inflight", 32'(dut1.inflight), 32'd1);
    chk("simul_post_count", 32'(dut1.fifo_count), 32'd2);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("simul_drain%0d_valid", j), 32'(rv1), 32'(j < 3));
      if (j < 3) begin
        chk($sformatf("simul_drain%0d_tag", j), 32'(ot1), 32'(11 + j));
        chk($sformatf("simul_drain%0d_data", j), d1, 32'h42000000 + 32'(11 + j));
      end
      $display("drain %0d: resp_valid=%0b resp_tag=%0d", j, rv1, ot1);
      @(posedge clk); #1;
    end

    // Reset with one in flight and two buffered.
    for (int k = 0; k < 3; k++) begin
      drive1(1'b1, 32'h43000000 + 32'(k), 32'h7F000000, TW'(20 + k), 1'b0);
      @(posedge clk); #1;
    end
    drive1(1'b0, 32'h43000000, 32'h7F000000, '0, 1'b1);
    areset = 1'b0;
    #2;
    chk("midreset_resp_valid", 32'(rv1), 32'd0);
    chk("midreset_ready", 32'(rdy1), 32'd1);
    chk("midreset_resp_data", d1, 32'd0);
    chk("midreset_resp_tag", 32'(ot1), 32'd0);
    @(posedge clk); #1;
    areset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("postreset%0d_resp_valid", j), 32'(rv1), 32'd0);
      chk($sformatf("postreset%0d_ready", j), 32'(rdy1), 32'd1);
      @(posedge clk); #1;
    end

    // LATENCY=3 random handshakes against a scoreboard.
    sent = 0; got = 0; cyc = 0; hold = 1'b0; hold_d = '0; hold_t = '0;
    while ((sent < NOPS || got < NOPS) && cyc < 20000) begin
      v3  = (sent < NOPS) && ($urandom_range(0, 1) == 1);
      a3  = $urandom;
      b3  = $urandom;
      t3  = TW'(sent);
      rr3 = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (hold) begin
        chk("rand_hold_valid", 32'(rv3), 32'd1);
        chk("rand_hold_data", d3, hold_d);
        chk("rand_hold_tag", 32'(ot3), 32'(hold_t));
      end
      chk("rand_overflow", 32'((dut3.fifo_count == 3'd4) && dut3.arrival), 32'd0);
      if (v3 && rdy3) begin
        sb.push_back('{data: fmin(a3, b3), tag: t3});
        sent++;
      end
      if (rv3 && rr3) begin
        if (sb.size() == 0) begin
          chk("rand_spurious_resp", 32'(rv3), 32'd0);
        end else begin
          exp_e = sb.pop_front();
          chk($sformatf("rand_resp%0d_data", got), d3, exp_e.data);
          chk($sformatf("rand_resp%0d_tag", got), 32'(ot3), 32'(exp_e.tag));
        end
        got++;
      end
      hold   = rv3 && !rr3;
      hold_d = d3;
      hold_t = ot3;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_completed_ops", 32'(got), 32'(NOPS));
    $display("random run: %0d sent, %0d received in %0d cycles", sent, got, cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
